// File: rtl/instr_encoder_if.sv
// Request/response bundle for instr_encoder: request fields in, encoded words and counters out.
// No state; pure signal grouping.
// slave is the encoder side, master is the producer/consumer side.
interface instr_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  fmt;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [2:0]  funct3;
  logic [31:0] imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_err;
  logic [15:0] enc_count;
  logic [15:0] err_count;

  modport slave (
    input  in_valid, fmt, rd, rs1, rs2, funct3, imm, out_ready,
    output in_ready, out_valid, out_instr, out_err, enc_count, err_count
  );

  modport master (
    output in_valid, fmt, rd, rs1, rs2, funct3, imm, out_ready,
    input  in_ready, out_valid, out_instr, out_err, enc_count, err_count
  );
endinterface

// File: rtl/instr_encoder.sv
// Packs RISC-V LOAD/OPIMM/STORE/BRANCH/JAL/JALR words from fields + signed immediate, into a DEPTH FIFO.
// Latency: 1 cycle from handshake to FIFO head when empty; no bypass.
// Backpressure: in_ready drops only when the FIFO is full (state-derived, no path from out_ready).
module instr_encoder #(
  parameter int DEPTH = 2
) (
  input logic            clk,
  input logic            rst,
  instr_encoder_if.slave bus
);
  localparam int          AW   = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE  = (AW+1)'(1);
  localparam logic [31:0] NOP  = 32'h00000013;

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] rd_nxt;
  logic [AW:0]   count;
  logic [32:0]   mem [DEPTH];
  logic [32:0]   head_q;
  logic [15:0]   enc_cnt_q;
  logic [15:0]   err_cnt_q;
  logic          in_rdy;
  logic          out_vld;
  logic          push;
  logic          pop;
  logic [31:0]   enc_word;
  logic          enc_err;
  logic          ok_is;
  logic          ok_b;
  logic          ok_j;

  assign in_rdy  = (count != FULL);
  assign out_vld = (count != '0);
  assign push    = bus.in_valid & in_rdy;
  assign pop     = out_vld & bus.out_ready;
  assign rd_nxt  = rd_ptr + AW'(1);

  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = out_vld;
  assign bus.out_instr = head_q[31:0];
  assign bus.out_err   = head_q[32];
  assign bus.enc_count = enc_cnt_q;
  assign bus.err_count = err_cnt_q;

  // Range-check the immediate and pack the word for the requested format; rejects become NOP.
  always_comb begin
    enc_word = NOP;
    enc_err  = 1'b0;
    ok_is = (&bus.imm[31:11]) | ~(|bus.imm[31:11]);
    ok_b  = ((&bus.imm[31:12]) | ~(|bus.imm[31:12])) & ~bus.imm[0];
    ok_j  = ((&bus.imm[31:20]) | ~(|bus.imm[31:20])) & ~bus.imm[0];
    case (bus.fmt)
      3'd0: begin
        enc_word = {bus.imm[11:0], bus.rs1, bus.funct3, bus.rd, 7'b0000011};
        enc_err  = ~ok_is;
      end
      3'd1: begin
        enc_word = {bus.imm[11:0], bus.rs1, bus.funct3, bus.rd, 7'b0010011};
        enc_err  = ~ok_is;
      end
      3'd2: begin
        enc_word = {bus.imm[11:5], bus.rs2, bus.rs1, bus.funct3, bus.imm[4:0], 7'b0100011};
        enc_err  = ~ok_is;
      end
      3'd3: begin
        enc_word = {bus.imm[12], bus.imm[10:5], bus.rs2, bus.rs1, bus.funct3,
                    bus.imm[4:1], bus.imm[11], 7'b1100011};
        enc_err  = ~ok_b;
      end
      3'd4: begin
        enc_word = {bus.imm[20], bus.imm[10:1], bus.imm[11], bus.imm[19:12], bus.rd, 7'b1101111};
        enc_err  = ~ok_j;
      end
      3'd5: begin
        enc_word = {bus.imm[11:0], bus.rs1, 3'b000, bus.rd, 7'b1100111};
        enc_err  = ~ok_is;
      end
      default: enc_err = 1'b1;
    endcase
    if (enc_err) enc_word = NOP;
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_nxt;
      if (push && !pop)      count <= count + ONE;
      else if (!push && pop) count <= count - ONE;
    end
  end

  // Storage array; contents need no reset because occupancy gates visibility.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {enc_err, enc_word};
  end

  // Head register: reloads only when the head entry changes, so it holds when the FIFO drains.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q <= '0;
    end else if (pop && count > ONE) begin
      head_q <= mem[rd_nxt];
    end else if (push && (count == '0 || (pop && count == ONE))) begin
      head_q <= {enc_err, enc_word};
    end
  end

  // Saturating handshake and reject counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      enc_cnt_q <= '0;
      err_cnt_q <= '0;
    end else if (push) begin
      if (enc_cnt_q != 16'hFFFF)            enc_cnt_q <= enc_cnt_q + 16'd1;
      if (enc_err && err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
    end
  end
endmodule
